// File: rtl/tc_event_tracker.sv
// ----------------------------------------------------------------------------
// tc_event_tracker
//
// Consumes the terminal-count (TC) level output of the DSP48E counter macro.
// It detects TC rising edges and decimates them by TC_PER_EVT to form qualified
// events. Each event produces a PULSE_LEN-cycle registered PULSE and sets a
// sticky IRQ, which ACK clears. EVT_CNT counts events and wraps. MISS_CNT
// counts events that arrive while the tracker is busy and saturates.
//
// Optional feature (macro TC_ACK_TIMEOUT_EN):
//   When defined, WAIT_ACK gives up after ACK_TIMEOUT cycles without ACK. IRQ
//   then drops and the sticky TIMEOUT flag is set. When undefined, WAIT_ACK
//   waits indefinitely and TIMEOUT is tied low.
//
// Ports:
//   CLK       in   rising-edge clock, shared with the counter macro
//   RST_N     in   asynchronous active-low reset
//   TC_IN     in   terminal count level from the counter
//   CLR       in   synchronous clear of EVT_CNT, MISS_CNT, decimator, TIMEOUT
//   ACK       in   IRQ acknowledge
//   PULSE     out  stretched event pulse (registered)
//   IRQ       out  sticky event flag (registered)
//   BUSY      out  FSM not idle
//   EVT_CNT   out  qualified event count (wraps)
//   MISS_CNT  out  events dropped while busy (saturates)
//   TIMEOUT   out  sticky ACK-timeout flag
// ----------------------------------------------------------------------------
module tc_event_tracker #(
    parameter int unsigned TC_PER_EVT  = 1,
    parameter int unsigned PULSE_LEN   = 4,
    parameter int unsigned EVT_CNT_W   = 16,
    parameter int unsigned MISS_CNT_W  = 8,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  TC_IN,
    input  logic                  CLR,
    input  logic                  ACK,
    output logic                  PULSE,
    output logic                  IRQ,
    output logic                  BUSY,
    output logic [EVT_CNT_W-1:0]  EVT_CNT,
    output logic [MISS_CNT_W-1:0] MISS_CNT,
    output logic                  TIMEOUT
);

    localparam int unsigned DIV_W = (TC_PER_EVT > 1) ? $clog2(TC_PER_EVT) : 1;
    localparam int unsigned STR_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TC_PER_EVT - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STRETCH  = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             tc_d;
    logic             tc_edge;
    logic             evt;
    logic [DIV_W-1:0] div_cnt;
    logic [STR_W-1:0] str_cnt, str_n;
    logic             pulse_n;
    logic             irq_n;

    // ------------------------------------------------------------------
    // Edge detect and decimation
    // ------------------------------------------------------------------
    assign tc_edge = TC_IN & ~tc_d;
    assign evt     = tc_edge && (div_cnt == DIV_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tc_d    <= 1'b0;
            div_cnt <= '0;
        end else begin
            tc_d <= TC_IN;
            if (CLR) begin
                div_cnt <= '0;
            end else if (tc_edge) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event and missed-event counters (CLR wins over increment)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            EVT_CNT  <= '0;
            MISS_CNT <= '0;
        end else if (CLR) begin
            EVT_CNT  <= '0;
            MISS_CNT <= '0;
        end else begin
            if (evt) begin
                EVT_CNT <= EVT_CNT + 1'b1;
            end
            if (evt && (state != IDLE) && (MISS_CNT != '1)) begin
                MISS_CNT <= MISS_CNT + 1'b1;
            end
        end
    end

    assign BUSY = (state != IDLE);

`ifdef TC_ACK_TIMEOUT_EN
    localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    logic [TMR_W-1:0] timer, timer_n;
    logic             timeout_n;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            str_cnt <= '0;
            PULSE   <= 1'b0;
            IRQ     <= 1'b0;
`ifdef TC_ACK_TIMEOUT_EN
            timer   <= '0;
            TIMEOUT <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            str_cnt <= str_n;
            PULSE   <= pulse_n;
            IRQ     <= irq_n;
`ifdef TC_ACK_TIMEOUT_EN
            timer   <= timer_n;
            TIMEOUT <= timeout_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        str_n     = str_cnt;
        pulse_n   = PULSE;
        // ACK clears IRQ in every state; an event in IDLE overrides it below.
        irq_n     = IRQ & ~ACK;
`ifdef TC_ACK_TIMEOUT_EN
        timer_n   = timer;
        timeout_n = TIMEOUT;
`endif
        case (state)
            IDLE: begin
                if (evt) begin
                    state_n = STRETCH;
                    str_n   = STR_LOAD;
                    pulse_n = 1'b1;
                    irq_n   = 1'b1;
                end
            end
            STRETCH: begin
                if (str_cnt == '0) begin
                    pulse_n = 1'b0;
                    // The decision uses IRQ after this cycle's ACK.
                    state_n = irq_n ? WAIT_ACK : IDLE;
`ifdef TC_ACK_TIMEOUT_EN
                    timer_n = '0;
`endif
                end else begin
                    str_n = str_cnt - 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ACK) begin
                    state_n = IDLE;
                end
`ifdef TC_ACK_TIMEOUT_EN
                else if (timer == TMR_LAST) begin
                    irq_n     = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
`ifdef TC_ACK_TIMEOUT_EN
        if (CLR) begin
            timeout_n = 1'b0;
        end
`endif
    end

`ifndef TC_ACK_TIMEOUT_EN
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_tc_event_tracker.sv
// ----------------------------------------------------------------------------
// tb_tc_event_tracker
//
// Scoreboard bench for tc_event_tracker. The stimulus process drives random
// and directed TC/CLR/ACK patterns. For each clock it runs an event-level
// reference model and queues the expected outputs. A monitor on the falling
// edge pops each entry and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_tc_event_tracker;

    localparam int N  = 3;   // TC edges per event
    localparam int PL = 4;   // pulse length
    localparam int EW = 6;   // event counter width (small so wrap is exercised)
    localparam int MW = 4;   // miss counter width (small so saturation is exercised)
    localparam int AT = 8;   // ACK timeout

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          TC_IN;
    logic          CLR;
    logic          ACK;
    logic          PULSE;
    logic          IRQ;
    logic          BUSY;
    logic [EW-1:0] EVT_CNT;
    logic [MW-1:0] MISS_CNT;
    logic          TIMEOUT;

    always #5 CLK = ~CLK;

    tc_event_tracker #(
        .TC_PER_EVT (N),
        .PULSE_LEN  (PL),
        .EVT_CNT_W  (EW),
        .MISS_CNT_W (MW),
        .ACK_TIMEOUT(AT)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .TC_IN   (TC_IN),
        .CLR     (CLR),
        .ACK     (ACK),
        .PULSE   (PULSE),
        .IRQ     (IRQ),
        .BUSY    (BUSY),
        .EVT_CNT (EVT_CNT),
        .MISS_CNT(MISS_CNT),
        .TIMEOUT (TIMEOUT)
    );

    typedef struct {
        bit pulse;
        bit irq;
        bit busy;
        bit tmo;
        int evt;
        int miss;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model, event level: pulse time remaining, pending IRQ, and
    // cycles spent waiting for ACK.
    bit m_tc_prev, m_irq, m_tmo;
    int m_div, m_rem, m_wait, m_evt, m_miss;

    function void model_reset();
        m_tc_prev = 0; m_irq = 0; m_tmo = 0;
        m_div = 0; m_rem = 0; m_wait = 0; m_evt = 0; m_miss = 0;
    endfunction

    function exp_t model_edge(bit tc, bit clr, bit ack);
        exp_t r;
        bit   rise, evt, busy;
        rise      = tc && !m_tc_prev;
        m_tc_prev = tc;
        evt       = rise && (m_div == N - 1);
        busy      = (m_rem > 0) || m_irq;
        if (clr) m_div = 0;
        else if (rise) m_div = (m_div + 1) % N;
        if (evt) m_evt = (m_evt + 1) % (1 << EW);
        if (evt && busy && m_miss < (1 << MW) - 1) m_miss++;
        if (clr) begin m_evt = 0; m_miss = 0; end
        if (!busy) begin
            if (evt) begin m_rem = PL; m_irq = 1; end
        end else if (m_rem > 0) begin
            m_rem--;
            if (ack) m_irq = 0;
            m_wait = 0;
        end else begin
            if (ack) m_irq = 0;
            else begin
                m_wait++;
`ifdef TC_ACK_TIMEOUT_EN
                if (m_wait == AT) begin m_irq = 0; m_tmo = 1; end
`endif
            end
        end
`ifdef TC_ACK_TIMEOUT_EN
        if (clr) m_tmo = 0;
`endif
        r.pulse = (m_rem > 0);
        r.irq   = m_irq;
        r.busy  = (m_rem > 0) || m_irq;
        r.tmo   = m_tmo;
        r.evt   = m_evt;
        r.miss  = m_miss;
        return r;
    endfunction

    task automatic step(input bit tc, input bit clr, input bit ack);
        exp_t e;
        TC_IN = tc; CLR = clr; ACK = ack;
        e = model_edge(tc, clr, ack);
        @(posedge CLK);
        #1;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (!PULSE && !IRQ && !BUSY && EVT_CNT == '0 && MISS_CNT == '0 && !TIMEOUT)
            passed++;
        else
            $display("FAIL %s: got pulse=%b irq=%b busy=%b evt=%0d miss=%0d tmo=%b, want all 0",
                     name, PULSE, IRQ, BUSY, EVT_CNT, MISS_CNT, TIMEOUT);
    endtask

    // Monitor: one expected entry per clock after the edge it describes.
    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (PULSE == e.pulse && IRQ == e.irq && BUSY == e.busy && TIMEOUT == e.tmo &&
                int'(EVT_CNT) == e.evt && int'(MISS_CNT) == e.miss)
                passed++;
            else
                $display("FAIL cycle t=%0t: got pulse=%b irq=%b busy=%b evt=%0d miss=%0d tmo=%b, want pulse=%b irq=%b busy=%b evt=%0d miss=%0d tmo=%b",
                         $time, PULSE, IRQ, BUSY, EVT_CNT, MISS_CNT, TIMEOUT,
                         e.pulse, e.irq, e.busy, e.evt, e.miss, e.tmo);
        end
    end

    initial begin
        RST_N = 1'b0; TC_IN = 1'b0; CLR = 1'b0; ACK = 1'b0;
        model_reset();
        #1 chk_zero("reset");
        @(posedge CLK); @(posedge CLK); #1;
        RST_N = 1'b1;

        // Isolated TC pulses, each ACKed 10 cycles later; every N-th is an event.
        for (int k = 0; k < 2 * N; k++) begin
            step(1, 0, 0);
            repeat (9) step(0, 0, 0);
            step(0, 0, 1);
            repeat (10) step(0, 0, 0);
        end

        // TC held high counts as a single edge.
        for (int k = 0; k < N; k++) begin
            repeat (20) step(1, 0, 0);
            repeat (4) step(0, 0, 0);
        end
        repeat (12) step(0, 0, 1);

        // Dense TC with no ACK: missed events saturate, pulse length unchanged.
        repeat (150) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        repeat (4) step(0, 0, 1);

        // Randomized traffic, including simultaneous evt/ACK and evt/CLR.
        repeat (3000) step($urandom_range(0, 99) < 40, $urandom_range(0, 999) < 3,
                           $urandom_range(0, 99) < 10);

        // Async reset in the middle of a stretched pulse.
        repeat (20) step(0, 0, 1);
        step(0, 1, 0);
        for (int k = 0; k < N; k++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        @(negedge CLK); #1;
        RST_N = 1'b0;
        #1 chk_zero("async_reset_mid_stretch");
        model_reset();
        @(posedge CLK); #1;
        RST_N = 1'b1;

        repeat (600) step($urandom_range(0, 99) < 50, $urandom_range(0, 999) < 5,
                          $urandom_range(0, 99) < 8);

        repeat (3) @(negedge CLK);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
